// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle MULT/DIV sequencer owning HI/LO, shared shift-add / restoring-divide datapath
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] p, mul_next, div_next;
  logic [WIDTH:0] md, ext_a, ext_b, abs_a, abs_b, add, trial;
  logic [2*WIDTH-1:0] prod;
  logic is_div, neg_q, neg_r, sgn, ge;
  // p holds {partial remainder / product high, multiplier / dividend-quotient}
  always_comb begin
    sgn = ~op[0];
    ext_a = {sgn & a[WIDTH-1], a};
    ext_b = {sgn & b[WIDTH-1], b};
    abs_a = ext_a[WIDTH] ? -ext_a : ext_a;
    abs_b = ext_b[WIDTH] ? -ext_b : ext_b;
    add = p[2*WIDTH:WIDTH] + (p[0] ? md : '0);
    mul_next = {1'b0, add, p[WIDTH-1:1]};
    trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    ge = trial >= md;
    div_next = {ge ? trial - md : trial, p[WIDTH-2:0], ge};
    prod = neg_q ? -p[2*WIDTH-1:0] : p[2*WIDTH-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      p <= '0;
      md <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      div_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (op == 3'd4) hi <= a;
          else if (op == 3'd5) lo <= a;
          else if (op < 3'd4) begin
            if (op[1] && b == '0) begin
              div_zero <= 1'b1;
              done <= 1'b1;
              state <= S_DONE;
            end else begin
              p <= {{(WIDTH+1){1'b0}}, op[1] ? abs_a[WIDTH-1:0] : abs_b[WIDTH-1:0]};
              md <= op[1] ? abs_b : abs_a;
              neg_q <= ext_a[WIDTH] ^ ext_b[WIDTH];
              neg_r <= ext_a[WIDTH];
              is_div <= op[1];
              div_zero <= 1'b0;
              cnt <= '0;
              busy <= 1'b1;
              state <= S_ITER;
            end
          end
        end
        S_ITER: begin
          p <= is_div ? div_next : mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= S_FIX;
        end
        S_FIX: begin
          if (is_div) begin
            lo <= neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
            hi <= neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
          end else {hi, lo} <= prod;
          busy <= 1'b0;
          done <= 1'b1;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized and directed checks of mdu_seq against an arithmetic reference model
module tb_mdu_seq;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic busy, done, div_zero;
  logic [31:0] hi, lo;
  int total = 0, bad = 0;
  logic [31:0] mh = '0, ml = '0;

  mdu_seq dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
               .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  // {hi,lo} expected from plain 64-bit arithmetic
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ux, uy;
    longint sx, sy, q, r;
    ux = o[0] ? {32'b0, x} : {{32{x[31]}}, x};
    uy = o[0] ? {32'b0, y} : {{32{y[31]}}, y};
    if (!o[1]) return ux * uy;
    sx = longint'(ux);
    sy = longint'(uy);
    q = sx / sy;
    r = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      output int lat, output int nb);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    nb = 0;
    for (lat = 0; lat < 50 && !done; lat++) begin
      nb += int'(busy);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int lat, nb;
    logic [63:0] e;
    logic z;
    z = o[1] && y == 0;
    e = z ? {mh, ml} : ref_op(o, x, y);
    exec(o, x, y, lat, nb);
    total++; if (lat !== (z ? 0 : 33)) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, z ? 0 : 33); end
    total++; if (nb !== (z ? 0 : 33)) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=%0d", nm, nb, z ? 0 : 33); end
    total++; if ({hi, lo} !== e) begin bad++; $display("FAIL %s hilo got=%h_%h exp=%h", nm, hi, lo, e); end
    total++; if (div_zero !== z) begin bad++; $display("FAIL %s div_zero got=%b exp=%b", nm, div_zero, z); end
    {mh, ml} = e;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_one_cycle got=%b exp=0", nm, done); end
  endtask

  task automatic test_reset;
    int lat, nb;
    total++; if ({busy, done, div_zero, hi, lo} !== 67'd0) begin bad++; $display("FAIL reset_state got=%b%b%b %h %h exp=0", busy, done, div_zero, hi, lo); end
    start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
    @(posedge clk); #1;
    op = 3'd1; a = 5; b = 7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if ({busy, done, hi, lo} !== 66'd0) begin bad++; $display("FAIL reset_mid_iter got=%b%b %h %h exp=0", busy, done, hi, lo); end
    @(posedge clk); #1 rst = 1'b0;
    mh = 0; ml = 0;
    exec(3'd1, 5, 7, lat, nb);
    total++; if (lat !== 33) begin bad++; $display("FAIL reset_rerun latency got=%0d exp=33", lat); end
    total++; if ({hi, lo} !== 64'd35) begin bad++; $display("FAIL reset_rerun hilo got=%h_%h exp=35", hi, lo); end
    ml = 35;
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    check_op("mult_m1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if ({hi, lo} !== 64'h1) begin bad++; $display("FAIL mult_m1_const got=%h_%h exp=1", hi, lo); end
    check_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL multu_max_const got=%h_%h", hi, lo); end
  endtask

  task automatic test_div;
    check_op("div_neg7", 3'd2, 32'hFFFF_FFF9, 2);
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg7_const got=%h_%h", hi, lo); end
    check_op("divu_7_2", 3'd3, 7, 2);
    total++; if ({hi, lo} !== {32'd1, 32'd3}) begin bad++; $display("FAIL divu_7_2_const got=%h_%h", hi, lo); end
    check_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_ovf_const got=%h_%h", hi, lo); end
  endtask

  task automatic test_div_zero;
    check_op("divu_zero", 3'd3, 9, 0);
    check_op("div_clear", 3'd2, 100, 7);
  endtask

  task automatic test_mt;
    int lat;
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    total++; if (hi !== 32'h1234_5678 || busy || done) begin bad++; $display("FAIL mthi got=%h b=%b d=%b exp=12345678", hi, busy, done); end
    op = 3'd5; a = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if ({hi, lo} !== 64'h1234_5678_9ABC_DEF0 || busy || done) begin bad++; $display("FAIL mtlo got=%h_%h b=%b d=%b", hi, lo, busy, done); end
    start = 1'b1; op = 3'd1; a = 2; b = 3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (hi !== 32'h1234_5678 || !busy) begin bad++; $display("FAIL mthi_busy got=%h busy=%b exp=12345678", hi, busy); end
    for (lat = 0; lat < 50 && !done; lat++) begin @(posedge clk); #1; end
    total++; if ({hi, lo} !== 64'd6) begin bad++; $display("FAIL mthi_busy_result got=%h_%h exp=6", hi, lo); end
    mh = 0; ml = 6;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int t, n, last;
    start = 1'b1; op = 3'd1; a = 3; b = 3;
    n = 0; last = 0;
    for (t = 0; t < 200 && n < 3; t++) begin
      @(posedge clk); #1;
      if (done) begin
        total++; if ({hi, lo} !== 64'd9) begin bad++; $display("FAIL held_result got=%h_%h exp=9", hi, lo); end
        if (n > 0) begin
          total++; if (t - last !== 35) begin bad++; $display("FAIL held_period got=%0d exp=35", t - last); end
        end
        last = t;
        n++;
      end
    end
    start = 1'b0;
    total++; if (n !== 3) begin bad++; $display("FAIL held_count got=%0d exp=3", n); end
    mh = 0; ml = 9;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic [2:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 0;
        1: x = 32'h8000_0000;
        2: y = 32'($urandom_range(1, 5));
        default: ;
      endcase
      check_op($sformatf("rand%0d_op%0d", i, o), o, x, y);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_mt;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
